// File: rtl/ps2_key_decoder.sv
// PS/2 (scan-code set 2) receiver that tracks which of seven piano keys are held.
// Reports the lowest held key, a held flag, and a one-cycle pulse on rejected frames.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] key_press,
    output logic       down,
    output logic       frame_err
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StCheck
    } state_e;

    logic            ps2c_s1_q, ps2c_s1_d;
    logic            ps2c_s2_q, ps2c_s2_d;
    logic            ps2c_prev_q, ps2c_prev_d;
    logic            ps2d_s1_q, ps2d_s1_d;
    logic            ps2d_s2_q, ps2d_s2_d;
    state_e          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [6:0]      held_q, held_d;
    logic            ext_q, ext_d;
    logic            brk_q, brk_d;
    logic [2:0]      key_press_q, key_press_d;
    logic            down_q, down_d;
    logic            frame_err_q, frame_err_d;

    logic            fall;
    logic            frame_ok;
    logic [6:0]      key_mask;

    // One-hot position of a piano key in the held mask; zero for unmapped codes.
    function automatic logic [6:0] key_onehot(input logic [7:0] code);
        unique case (code)
            8'h1C:   return 7'b000_0001;
            8'h1B:   return 7'b000_0010;
            8'h23:   return 7'b000_0100;
            8'h2B:   return 7'b000_1000;
            8'h34:   return 7'b001_0000;
            8'h33:   return 7'b010_0000;
            8'h3B:   return 7'b100_0000;
            default: return 7'b000_0000;
        endcase
    endfunction

    assign fall = ps2c_prev_q & ~ps2c_s2_q;

    always_comb begin
        ps2c_s1_d   = ps2_clk;
        ps2c_s2_d   = ps2c_s1_q;
        ps2c_prev_d = ps2c_s2_q;
        ps2d_s1_d   = ps2_data;
        ps2d_s2_d   = ps2d_s1_q;

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tmo_cnt_d   = tmo_cnt_q;
        held_d      = held_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        frame_err_d = 1'b0;
        frame_ok    = 1'b0;
        key_mask    = 7'b0;

        unique case (state_q)
            StIdle: begin
                tmo_cnt_d = '0;
                if (fall && !ps2d_s2_q) begin
                    state_d   = StRecv;
                    bit_cnt_d = 4'd1;
                end
            end
            StRecv: begin
                if (tmo_cnt_q == CntMax) begin
                    // Timeout takes precedence over a coincident edge.
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end else if (fall) begin
                    shift_d   = {ps2d_s2_q, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tmo_cnt_d = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = StCheck;
                    end
                end else begin
                    // Pulse lands in the same cycle the counter reads CntMax.
                    tmo_cnt_d   = tmo_cnt_q + 1'b1;
                    frame_err_d = (tmo_cnt_d == CntMax);
                end
            end
            StCheck: begin
                state_d   = StIdle;
                bit_cnt_d = '0;
                tmo_cnt_d = '0;
                frame_ok  = shift_q[9] && (^shift_q[8:0]);
                key_mask  = key_onehot(shift_q[7:0]);
                if (!frame_ok) begin
                    frame_err_d = 1'b1;
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                end else if (shift_q[7:0] == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (shift_q[7:0] == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    if (!ext_q && (key_mask != 7'b0)) begin
                        held_d = brk_q ? (held_q & ~key_mask) : (held_q | key_mask);
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        key_press_d = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (held_q[i]) begin
                key_press_d = 3'(i + 1);
            end
        end
        down_d = |held_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_cnt_q   <= '0;
            held_q      <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_press_q <= 3'd0;
            down_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ps2c_s1_q   <= ps2c_s1_d;
            ps2c_s2_q   <= ps2c_s2_d;
            ps2c_prev_q <= ps2c_prev_d;
            ps2d_s1_q   <= ps2d_s1_d;
            ps2d_s2_q   <= ps2d_s2_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_cnt_q   <= tmo_cnt_d;
            held_q      <= held_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_press_q <= key_press_d;
            down_q      <= down_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign key_press = key_press_q;
    assign down      = down_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, corner sequences,
// and random frames compared against a key-set model.
module tb_ps2_key_decoder;

    localparam int unsigned TMO  = 200;
    localparam int          HALF = 8;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [2:0] key_press;
    logic       down;
    logic       frame_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_seen = 0;
    logic err_prev = 1'b0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_press(key_press),
        .down     (down),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count error pulses and make sure none lasts longer than one cycle.
    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            err_seen++;
            n_checks++;
            if (err_prev === 1'b1) begin
                n_fail++;
                $display("FAIL frame_err_width: high 2 consecutive cycles, required 1 cycle");
            end
        end
        err_prev = frame_err;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference model: set of held keys plus the two prefix flags.
    bit [7:1] m_held;
    bit       m_ext;
    bit       m_brk;

    function automatic int key_of(input logic [7:0] c);
        case (c)
            8'h1C:   return 1;
            8'h1B:   return 2;
            8'h23:   return 3;
            8'h2B:   return 4;
            8'h34:   return 5;
            8'h33:   return 6;
            8'h3B:   return 7;
            default: return 0;
        endcase
    endfunction

    task automatic model_frame(input logic [7:0] c, input bit ok);
        int k;
        if (!ok) begin
            m_ext = 0;
            m_brk = 0;
        end else if (c == 8'hE0) begin
            m_ext = 1;
        end else if (c == 8'hF0) begin
            m_brk = 1;
        end else begin
            k = key_of(c);
            if (!m_ext && k != 0) m_held[k] = !m_brk;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    function automatic int model_key();
        for (int i = 1; i <= 7; i++) if (m_held[i]) return i;
        return 0;
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1;
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        repeat (6) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        int         exp_key;
        int         exp_down;
        int         exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [7:0] code, input bit bp, input bit bs,
                           input int k, input int d, input int e);
        vec_t v;
        v.code     = code;
        v.bad_par  = bp;
        v.bad_stop = bs;
        v.exp_key  = k;
        v.exp_down = d;
        v.exp_err  = e;
        vecs.push_back(v);
    endtask

    logic [7:0] key_codes [7] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B};

    initial begin
        int         e0;
        logic [7:0] c;
        bit         bp;
        bit         bs;
        int         r;
        logic [10:0] f;

        add_vec(8'h1C, 0, 0, 1, 1, 0);
        add_vec(8'hF0, 0, 0, 1, 1, 0);
        add_vec(8'h1C, 0, 0, 0, 0, 0);
        add_vec(8'h34, 0, 0, 5, 1, 0);
        add_vec(8'h1B, 0, 0, 2, 1, 0);
        add_vec(8'hF0, 0, 0, 2, 1, 0);
        add_vec(8'h1B, 0, 0, 5, 1, 0);
        add_vec(8'h23, 1, 0, 5, 1, 1);
        add_vec(8'h23, 0, 0, 3, 1, 0);
        add_vec(8'hF0, 0, 0, 3, 1, 0);
        add_vec(8'h23, 0, 0, 5, 1, 0);
        add_vec(8'hF0, 0, 0, 5, 1, 0);
        add_vec(8'h34, 0, 0, 0, 0, 0);
        add_vec(8'hE0, 0, 0, 0, 0, 0);
        add_vec(8'h1C, 0, 0, 0, 0, 0);
        add_vec(8'hF0, 0, 0, 0, 0, 0);
        add_vec(8'h1C, 0, 1, 0, 0, 1);
        add_vec(8'h2B, 0, 0, 4, 1, 0);
        add_vec(8'h33, 0, 0, 4, 1, 0);
        add_vec(8'hF0, 0, 0, 4, 1, 0);
        add_vec(8'h2B, 0, 0, 6, 1, 0);
        add_vec(8'h33, 0, 0, 6, 1, 0);
        add_vec(8'hF0, 0, 0, 6, 1, 0);
        add_vec(8'h33, 0, 0, 0, 0, 0);

        // Reset with the bus idle.
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_key_press", int'(key_press), 0);
        check("reset_down", int'(down), 0);
        check("reset_frame_err", int'(frame_err), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            e0 = err_seen;
            send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
            model_frame(vecs[i].code, !vecs[i].bad_par && !vecs[i].bad_stop);
            check($sformatf("vec%0d_key_press", i), int'(key_press), vecs[i].exp_key);
            check($sformatf("vec%0d_down", i), int'(down), vecs[i].exp_down);
            check($sformatf("vec%0d_frame_err", i), err_seen - e0, vecs[i].exp_err);
        end

        // Reset in the middle of a frame drops the frame and clears held keys.
        send_frame(8'h1C, 0, 0);
        model_frame(8'h1C, 1);
        check("pre_midrst_key_press", int'(key_press), 1);
        f = {1'b1, ~^8'h34, 8'h34, 1'b0};
        for (int i = 0; i < 5; i++) ps2_bit(f[i]);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_key_press", int'(key_press), 0);
        check("midrst_down", int'(down), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        m_held = '0;
        m_ext  = 0;
        m_brk  = 0;
        repeat (4) @(posedge clk);
        #1;
        send_frame(8'h1B, 0, 0);
        model_frame(8'h1B, 1);
        check("post_midrst_key_press", int'(key_press), 2);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1B, 0, 0);
        model_frame(8'hF0, 1);
        model_frame(8'h1B, 1);
        check("post_midrst_release", int'(key_press), 0);

        // Timeout: F0 primes the break flag, then a stalled frame must clear it.
        send_frame(8'hF0, 0, 0);
        model_frame(8'hF0, 1);
        f = {1'b1, ~^8'h3B, 8'h3B, 1'b0};
        for (int i = 0; i < 4; i++) ps2_bit(f[i]);
        e0 = err_seen;
        ps2_data = f[4];
        repeat (HALF) @(posedge clk);
        #1;
        ps2_clk = 1'b0;
        // Three-stage edge detect puts the pulse TMO+3 edges after the pin drop.
        for (int k = 1; k <= int'(TMO) + 4; k++) begin
            @(posedge clk);
            #1;
            if (k == HALF) ps2_clk = 1'b1;
            if (k == int'(TMO) + 2) check("timeout_before", int'(frame_err), 0);
            if (k == int'(TMO) + 3) check("timeout_pulse", int'(frame_err), 1);
            if (k == int'(TMO) + 4) check("timeout_after", int'(frame_err), 0);
        end
        check("timeout_err_count", err_seen - e0, 1);
        model_frame(8'h00, 0);
        send_frame(8'h3B, 0, 0);
        model_frame(8'h3B, 1);
        check("after_timeout_key_press", int'(key_press), 7);
        check("after_timeout_down", int'(down), 1);

        // Random traffic against the model.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 11);
            if (r < 7) c = key_codes[r];
            else if (r < 10) c = 8'hF0;
            else if (r == 10) c = 8'hE0;
            else c = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 19) == 0);
            e0 = err_seen;
            send_frame(c, bp, bs);
            model_frame(c, !bp && !bs);
            check($sformatf("rnd%0d_key_press(code %02h)", n, c), int'(key_press), model_key());
            check($sformatf("rnd%0d_down", n), int'(down), (m_held != 0) ? 1 : 0);
            check($sformatf("rnd%0d_frame_err", n), err_seen - e0, (bp || bs) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
